// File: rtl/spi_mem.sv
// spi_mem
// -------
// 16 x 8-bit register memory sitting behind the SPI slave datapath.
// The SPI front end supplies a word address plus read/write strobes; write
// data comes from the SPI receive buffer and read data is registered into
// buffer_tx, which the SPI shifter loads.
//
// Every access completes on a single rising edge of mem_clk. Asserting
// mem_initial restores a known image (word i holds i) and clears buffer_tx.
//
// Ports:
//   mem_clk      in   1  system clock, rising-edge active
//   mem_initial  in   1  synchronous active-high initialize (highest priority)
//   mem_en       in   1  block enable; low means no access takes effect
//   mem_address  in   4  word address 0x0..0xF
//   mem_we       in   1  write strobe (wins over mem_re)
//   mem_re       in   1  read strobe
//   buffer_rx    in   8  write data
//   buffer_tx    out  8  registered read data, 1-cycle latency
//
// Strobes are level-sensitive: a strobe held for k cycles performs k
// accesses. There is no handshake; the caller owns the timing.
module spi_mem (
  input  logic       mem_clk,
  input  logic       mem_initial,
  input  logic       mem_en,
  input  logic [3:0] mem_address,
  input  logic       mem_we,
  input  logic       mem_re,
  input  logic [7:0] buffer_rx,
  output logic [7:0] buffer_tx
);

  logic [7:0] m [16];

  // Priority order: initialize, enable, write, read. mem_initial and mem_en
  // are tested before any other input so that unknown strobes, address or
  // data cannot disturb state while the block is initializing or disabled.
  always_ff @(posedge mem_clk) begin
    if (mem_initial) begin
      for (int i = 0; i < 16; i++) begin
        m[i] <= 8'(i);
      end
      buffer_tx <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) begin
        // A simultaneous read is dropped; buffer_tx holds.
        m[mem_address] <= buffer_rx;
      end else if (mem_re) begin
        buffer_tx <= m[mem_address];
      end
    end
  end

endmodule

// File: tb/tb_spi_mem.sv
// Directed testbench for spi_mem. Inputs change 1 time unit after a rising
// edge and buffer_tx is sampled at the same offset, away from the edge.
module tb_spi_mem;

  logic       mem_clk;
  logic       mem_initial;
  logic       mem_en;
  logic [3:0] mem_address;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] buffer_rx;
  logic [7:0] buffer_tx;

  int checks;
  int failures;

  spi_mem dut (
    .mem_clk     (mem_clk),
    .mem_initial (mem_initial),
    .mem_en      (mem_en),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .buffer_rx   (buffer_rx),
    .buffer_tx   (buffer_tx)
  );

  // Clock block
  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Driver: set all inputs, then advance past one rising edge.
  task automatic drive(input logic init, input logic en, input logic we,
                       input logic re, input logic [3:0] addr,
                       input logic [7:0] rx);
    mem_initial = init;
    mem_en      = en;
    mem_we      = we;
    mem_re      = re;
    mem_address = addr;
    buffer_rx   = rx;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (buffer_tx === exp) else begin
      failures++;
      $error("FAIL %s: buffer_tx=%h expected=%h", tag, buffer_tx, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_v;
    checks   = 0;
    failures = 0;
    mem_initial = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_address = 4'h0;
    buffer_rx   = 8'h00;
    @(posedge mem_clk);
    #1;

    // Initialize held for 4 edges, strobes ignored meanwhile.
    drive(1, 1, 1, 1, 4'h9, 8'hEE);
    drive(1, 1, 0, 1, 4'h9, 8'hEE);
    drive(1, 1, 0, 0, 4'h0, 8'h00);
    drive(1, 1, 0, 0, 4'h0, 8'h00);
    check("init_tx", 8'h00);

    // Reads of the initial image.
    drive(0, 1, 0, 1, 4'h0, 8'h00);
    check("rd_init_0", 8'h00);
    drive(0, 1, 0, 1, 4'h5, 8'h00);
    check("rd_init_5", 8'h05);
    drive(0, 1, 0, 1, 4'hF, 8'h00);
    check("rd_init_f", 8'h0F);
    drive(0, 1, 0, 0, 4'h9, 8'h00);
    check("idle_hold", 8'h0F);
    // Strobe-X immunity sanity: initialize image word 9 untouched by above.
    drive(0, 1, 0, 1, 4'h9, 8'h00);
    check("rd_init_9", 8'h09);

    // Read, write, read at 0xA.
    drive(0, 1, 0, 1, 4'hA, 8'hF0);
    check("rwr_rd1", 8'h0A);
    drive(0, 1, 0, 1, 4'hA, 8'hF0);
    check("rwr_rd2", 8'h0A);
    drive(0, 1, 1, 0, 4'hA, 8'hF0);
    check("rwr_wr1_hold", 8'h0A);
    drive(0, 1, 1, 0, 4'hA, 8'hF0);
    check("rwr_wr2_hold", 8'h0A);
    drive(0, 1, 0, 1, 4'hA, 8'h00);
    check("rwr_rd_new", 8'hF0);

    // Enable gating.
    drive(0, 0, 1, 0, 4'h3, 8'h55);
    check("en0_wr_hold", 8'hF0);
    drive(0, 0, 0, 1, 4'h3, 8'h55);
    check("en0_rd_hold", 8'hF0);
    drive(0, 1, 0, 1, 4'h3, 8'h00);
    check("en1_rd_3", 8'h03);

    // Simultaneous strobes: write wins, no read.
    drive(0, 1, 1, 1, 4'h7, 8'hAB);
    check("wr_rd_hold", 8'h03);
    drive(0, 1, 0, 1, 4'h7, 8'h00);
    check("rd_7", 8'hAB);

    // Initialize over write.
    drive(0, 1, 1, 0, 4'h2, 8'hCC);
    drive(0, 1, 0, 1, 4'h2, 8'h00);
    check("rd_2_cc", 8'hCC);
    drive(1, 1, 1, 0, 4'h2, 8'h99);
    check("init_over_wr_tx", 8'h00);
    drive(0, 1, 0, 1, 4'h2, 8'h00);
    check("init_over_wr_rd2", 8'h02);
    drive(0, 1, 0, 1, 4'h7, 8'h00);
    check("init_restores_7", 8'h07);

    // Full sweep: write ~i everywhere, read back with mem_re held high.
    for (int i = 0; i < 16; i++) begin
      exp_v = 8'(i);
      drive(0, 1, 1, 0, 4'(i), ~exp_v);
    end
    check("sweep_wr_hold", 8'h07);
    for (int i = 0; i < 16; i++) begin
      exp_v = 8'(i);
      drive(0, 1, 0, 1, 4'(i), 8'h00);
      check($sformatf("sweep_rd_%0d", i), ~exp_v);
    end
    drive(0, 1, 0, 0, 4'h0, 8'h00);
    check("sweep_end_hold", 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
